// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module : hazard_pkg
//  Shared opcodes, NOP encoding and sequencer state encoding for hazard_ctrl.
//  Rev    : 1.0
// ============================================================================
package hazard_pkg;

  localparam logic [6:0] R_TYPE_OP    = 7'b0110011;
  localparam logic [6:0] I_TYPE_OP    = 7'b0010011;
  localparam logic [6:0] LD_TYPE_OP   = 7'b0000011;
  localparam logic [6:0] JALR_TYPE_OP = 7'b1100111;
  localparam logic [6:0] S_TYPE_OP    = 7'b0100011;
  localparam logic [6:0] SB_TYPE_OP   = 7'b1100011;
  localparam logic [6:0] U_TYPE_OP    = 7'b0110111;
  localparam logic [6:0] UJ_TYPE_OP   = 7'b1101111;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  function automatic logic op_uses_rs1(input logic [6:0] op);
    logic uses;
    uses = 1'b0;
    case (op)
      R_TYPE_OP, I_TYPE_OP, LD_TYPE_OP,
      JALR_TYPE_OP, S_TYPE_OP, SB_TYPE_OP: uses = 1'b1;
      U_TYPE_OP, UJ_TYPE_OP:               uses = 1'b0;
      default:                             uses = 1'b0;
    endcase
    return uses;
  endfunction

  function automatic logic op_uses_rs2(input logic [6:0] op);
    return (op == R_TYPE_OP) || (op == S_TYPE_OP) || (op == SB_TYPE_OP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module : hazard_ctrl_if
//  Pipeline-side bundle between the ID stage and the hazard sequencer.
//  Rev    : 1.0
// ============================================================================
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_inst;
  logic             id_valid;
  logic             control_j;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             mem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_inst, id_valid, control_j, ex_mem_read, ex_rd, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_inst, id_valid, control_j, ex_mem_read, ex_rd, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module : sat_counter
//  Up-counter that sticks at all-ones instead of wrapping.
//  Rev    : 1.0
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  assign cnt = cnt_q;
endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : hazard_ctrl
//  Load-use / jump-flush / memory-wait sequencer driving PC, IF/ID and ID/EX.
//  Rev    : 1.0
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);
  localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYC - 1);
  localparam bit         MULTI_FLUSH = (FLUSH_CYC > 1);

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       load_use;
  logic       unused_inst_bits;

  assign opcode   = bus.id_inst[6:0];
  assign rs1      = bus.id_inst[19:15];
  assign rs2      = bus.id_inst[24:20];
  assign uses_rs1 = op_uses_rs1(opcode);
  assign uses_rs2 = op_uses_rs2(opcode);
  assign unused_inst_bits = ^{bus.id_inst[31:25], bus.id_inst[14:7]};

  assign load_use = bus.id_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((uses_rs1 && (bus.ex_rd == rs1)) ||
                     (uses_rs2 && (bus.ex_rd == rs2)));

  state_e     state_q, state_d;
  logic [2:0] flush_ctr_q, flush_ctr_d;
  logic       resume_q, resume_d;
  logic       eval_run, eval_flush;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      flush_ctr_q <= 3'd0;
      resume_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_ctr_q <= flush_ctr_d;
      resume_q    <= resume_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_ctr_d = flush_ctr_q;
    resume_d    = resume_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    eval_run    = 1'b0;
    eval_flush  = 1'b0;

    // Leaving MEM_WAIT evaluates the resumed state's rules in the same cycle.
    case (state_q)
      ST_RUN: eval_run = 1'b1;
      ST_MEM_WAIT: begin
        if (bus.mem_busy) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
        end else if (resume_q) begin
          eval_flush = 1'b1;
        end else begin
          eval_run = 1'b1;
        end
      end
      ST_FLUSH: eval_flush = 1'b1;
      default:  state_d = ST_RUN;
    endcase

    if (eval_run) begin
      if (bus.mem_busy) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        state_d    = ST_MEM_WAIT;
        resume_d   = 1'b0;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        state_d     = ST_RUN;
      end else if (bus.control_j) begin
        ifid_flush  = 1'b1;
        flush_ctr_d = FLUSH_INIT;
        state_d     = MULTI_FLUSH ? ST_FLUSH : ST_RUN;
      end else begin
        state_d = ST_RUN;
      end
    end

    if (eval_flush) begin
      if (bus.mem_busy) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        state_d    = ST_MEM_WAIT;
        resume_d   = 1'b1;
      end else begin
        ifid_flush  = 1'b1;
        resume_d    = 1'b0;
        flush_ctr_d = (flush_ctr_q != 3'd0) ? (flush_ctr_q - 3'd1) : 3'd0;
        state_d     = (flush_ctr_q <= 3'd1) ? ST_RUN : ST_FLUSH;
      end
    end

    if (reset) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~pc_write),
    .cnt   (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ifid_flush),
    .cnt   (bus.flush_cnt)
  );
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : tb_hazard_ctrl
//  Scoreboard bench: per-cycle expected enables queued at drive, popped at negedge.
//  Rev    : 1.0
// ============================================================================
module tb_hazard_ctrl;
  import hazard_pkg::*;

  // {pc_write, ifid_write, ifid_flush, idex_bubble}
  localparam logic [3:0] E_RUN   = 4'b1100;
  localparam logic [3:0] E_STALL = 4'b0001;
  localparam logic [3:0] E_FRZ   = 4'b0000;
  localparam logic [3:0] E_FL    = 4'b1110;

  logic clk;
  logic reset;
  logic rst_sat;
  int   errors;
  int   checks;

  logic [3:0] exp_q[$];
  string      name_q[$];
  logic [3:0] mon_exp;
  logic [3:0] mon_got;
  string      mon_name;

  hazard_ctrl_if #(.CNT_W(16)) hif ();
  hazard_ctrl_if #(.CNT_W(2))  sif ();

  hazard_ctrl #(.FLUSH_CYC(2), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif)
  );

  hazard_ctrl #(.FLUSH_CYC(1), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (rst_sat),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_got  = {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.idex_bubble};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL %s: {pc_w,ifid_w,flush,bubble} got=%b exp=%b", mon_name, mon_got, mon_exp);
      end
    end
  end

  function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, R_TYPE_OP};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, I_TYPE_OP};
  endfunction

  task automatic cyc(input logic rst_v, input logic [31:0] inst, input logic valid,
                     input logic j, input logic mr, input logic [4:0] rd,
                     input logic busy, input logic [3:0] exp, input string name);
    @(posedge clk);
    #1;
    reset           = rst_v;
    hif.id_inst     = inst;
    hif.id_valid    = valid;
    hif.control_j   = j;
    hif.ex_mem_read = mr;
    hif.ex_rd       = rd;
    hif.mem_busy    = busy;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  task automatic idle(input string name);
    cyc(1'b0, NOP_INST, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, E_RUN, name);
  endtask

  task automatic do_reset();
    cyc(1'b1, NOP_INST, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, E_RUN, "reset_hold");
  endtask

  task automatic test_reset();
    cyc(1'b1, NOP_INST, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, E_RUN, "reset_overrides_inputs");
    cyc(1'b1, NOP_INST, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, E_RUN, "reset_hold2");
    idle("reset_release");
    checks++;
    if (hif.stall_cnt !== 16'd0 || hif.flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: stall=%0d flush=%0d exp 0/0", hif.stall_cnt, hif.flush_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    cyc(1'b0, r_type(5'd6, 5'd5, 5'd7), 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, E_STALL, "lu_rs1");
    cyc(1'b0, r_type(5'd6, 5'd5, 5'd7), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, E_RUN, "lu_rs1_release");
    checks++;
    if (hif.stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL lu_stall_cnt: got=%0d exp=1", hif.stall_cnt);
    end
    cyc(1'b0, r_type(5'd6, 5'd7, 5'd5), 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, E_STALL, "lu_rs2");
    cyc(1'b0, r_type(5'd6, 5'd7, 5'd5), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, E_RUN, "lu_rs2_release");
    cyc(1'b0, r_type(5'd6, 5'd5, 5'd7), 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, E_RUN, "lu_id_bubble");
    idle("lu_idle");
    checks++;
    if (hif.stall_cnt !== 16'd2 || hif.flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL lu_counters: stall=%0d flush=%0d exp 2/0", hif.stall_cnt, hif.flush_cnt);
    end
  endtask

  task automatic test_no_false_hazard();
    logic [31:0] lui;
    lui = {12'h000, 5'd5, 3'b000, 5'd6, U_TYPE_OP};
    do_reset();
    cyc(1'b0, r_type(5'd6, 5'd0, 5'd0), 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, E_RUN, "nf_x0");
    cyc(1'b0, addi(5'd6, 5'd5, 12'd1), 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, E_RUN, "nf_not_load");
    cyc(1'b0, addi(5'd6, 5'd7, 12'd1), 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, E_RUN, "nf_addi_no_rs2");
    cyc(1'b0, lui, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, E_RUN, "nf_lui_no_rs1");
    cyc(1'b0, addi(5'd6, 5'd5, 12'd1), 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, E_STALL, "nf_addi_real");
    idle("nf_release");
    checks++;
    if (hif.stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL nf_stall_cnt: got=%0d exp=1", hif.stall_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    cyc(1'b0, NOP_INST, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, E_FL, "fl_jump");
    cyc(1'b0, NOP_INST, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, E_FL, "fl_second_ignores_j");
    idle("fl_done");
    checks++;
    if (hif.flush_cnt !== 16'd2 || hif.stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL fl_counters: flush=%0d stall=%0d exp 2/0", hif.flush_cnt, hif.stall_cnt);
    end
    idle("fl_stays_run");
  endtask

  task automatic test_mem_wait();
    do_reset();
    cyc(1'b0, NOP_INST, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, E_FL, "mw_jump");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, NOP_INST, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, E_FRZ, "mw_frozen_in_flush");
    cyc(1'b0, NOP_INST, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, E_FL, "mw_resume_flush");
    idle("mw_back_to_run");
    checks++;
    if (hif.stall_cnt !== 16'd3 || hif.flush_cnt !== 16'd2) begin
      errors++;
      $display("FAIL mw_counters: stall=%0d flush=%0d exp 3/2", hif.stall_cnt, hif.flush_cnt);
    end
    cyc(1'b0, r_type(5'd6, 5'd5, 5'd7), 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, E_FRZ, "mw_busy_beats_all");
    cyc(1'b0, r_type(5'd6, 5'd5, 5'd7), 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, E_FRZ, "mw_hold");
    cyc(1'b0, r_type(5'd6, 5'd5, 5'd7), 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, E_STALL, "mw_exit_same_cycle");
    idle("mw_release");
    checks++;
    if (hif.stall_cnt !== 16'd6) begin
      errors++;
      $display("FAIL mw_stall_total: got=%0d exp=6", hif.stall_cnt);
    end
  endtask

  task automatic test_priority();
    do_reset();
    cyc(1'b0, r_type(5'd6, 5'd5, 5'd7), 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, E_STALL, "pr_stall_wins");
    cyc(1'b0, r_type(5'd6, 5'd5, 5'd7), 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, E_FL, "pr_jump_resampled");
    cyc(1'b0, NOP_INST, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, E_FL, "pr_flush2");
    idle("pr_done");
    checks++;
    if (hif.stall_cnt !== 16'd1 || hif.flush_cnt !== 16'd2) begin
      errors++;
      $display("FAIL pr_counters: stall=%0d flush=%0d exp 1/2", hif.stall_cnt, hif.flush_cnt);
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    cyc(1'b0, NOP_INST, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, E_FL, "rf_jump");
    cyc(1'b1, NOP_INST, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, E_RUN, "rf_reset_in_flush");
    idle("rf_run_after_reset");
    checks++;
    if (hif.stall_cnt !== 16'd0 || hif.flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rf_counters: stall=%0d flush=%0d exp 0/0", hif.stall_cnt, hif.flush_cnt);
    end
  endtask

  task automatic test_saturation();
    @(posedge clk);
    #1;
    rst_sat = 1'b1;
    @(posedge clk);
    #1;
    rst_sat      = 1'b0;
    sif.mem_busy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 2 || i == 3 || i == 5) begin
        checks++;
        if (sif.stall_cnt !== ((i >= 3) ? 2'd3 : 2'd2)) begin
          errors++;
          $display("FAIL sat_stall_cnt[%0d]: got=%0d exp=%0d", i, sif.stall_cnt,
                   (i >= 3) ? 3 : 2);
        end
      end
    end
    sif.mem_busy  = 1'b0;
    sif.control_j = 1'b1;
    #1;
    checks++;
    if (sif.ifid_flush !== 1'b1 || sif.pc_write !== 1'b1) begin
      errors++;
      $display("FAIL sat_single_flush: flush=%b pc_w=%b exp 1/1", sif.ifid_flush, sif.pc_write);
    end
    @(posedge clk);
    #1;
    sif.control_j = 1'b0;
    #1;
    checks++;
    if (sif.ifid_flush !== 1'b0 || sif.pc_write !== 1'b1 || sif.flush_cnt !== 2'd1) begin
      errors++;
      $display("FAIL sat_flush_cyc1_done: flush=%b pc_w=%b flush_cnt=%0d exp 0/1/1",
               sif.ifid_flush, sif.pc_write, sif.flush_cnt);
    end
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    reset           = 1'b1;
    rst_sat         = 1'b1;
    hif.id_inst     = NOP_INST;
    hif.id_valid    = 1'b0;
    hif.control_j   = 1'b0;
    hif.ex_mem_read = 1'b0;
    hif.ex_rd       = 5'd0;
    hif.mem_busy    = 1'b0;
    sif.id_inst     = NOP_INST;
    sif.id_valid    = 1'b0;
    sif.control_j   = 1'b0;
    sif.ex_mem_read = 1'b0;
    sif.ex_rd       = 5'd0;
    sif.mem_busy    = 1'b0;

    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_mem_wait();
    test_priority();
    test_reset_mid_flush();
    test_saturation();

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
